lsu_mem_master: RTL and testbench

//  Load/store unit for RV32I. Sits between the core's memory stage and the

---
 rtl/lsu_mem_master_if.sv | 33 +++
 rtl/lsu_mem_master.sv | 167 ++++++++++++++++
 tb/tb_lsu_mem_master.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_master_if.sv
// Bundle of the core request/response handshake and the data memory port.
//   master : the load/store unit (drives req_ready, rsp_*, mem_we/addr/wdata)
//   slave  : core + memory side (drives req_*, rsp_ready, mem_rdata)
interface lsu_mem_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_mem_master.sv
// RV32I load/store unit in front of a word-wide synchronous data memory.
// Sequences byte/half/word loads and stores (sub-word stores by read-modify-write)
// and flags misaligned, out-of-range and illegal-funct3 requests.
//   clk, rst_n : clock, asynchronous active-low reset
//   lsu        : request/response handshake and memory port (master side)
module lsu_mem_master #(
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    lsu_mem_master_if.master  lsu
);
    localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH_WORDS * 4);
    localparam logic [2:0]  F3_B  = 3'b000;
    localparam logic [2:0]  F3_H  = 3'b001;
    localparam logic [2:0]  F3_W  = 3'b010;
    localparam logic [2:0]  F3_BU = 3'b100;
    localparam logic [2:0]  F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, ACCESS, DATA, RESP} state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        illegal_c;
    logic [7:0]  byte_c;
    logic [15:0] half_c;
    logic [31:0] load_c;
    logic [31:0] merge_c;
    logic        req_ready_c, rsp_valid_c, mem_we_c;
    logic [31:0] mem_addr_c, mem_wdata_c;

    // Legality of the incoming request (funct3 set depends on load vs store)
    always_comb begin
        illegal_c = 1'b0;
        unique case (lsu.req_funct3)
            F3_B:          illegal_c = 1'b0;
            F3_BU:         illegal_c = lsu.req_we;
            F3_H:          illegal_c = lsu.req_addr[0];
            F3_HU:         illegal_c = lsu.req_we | lsu.req_addr[0];
            F3_W:          illegal_c = |lsu.req_addr[1:0];
            default:       illegal_c = 1'b1;
        endcase
        if (lsu.req_addr >= ADDR_LIMIT) illegal_c = 1'b1;
    end

    // Lane extraction for loads and lane replacement for sub-word stores
    always_comb begin
        byte_c  = lsu.mem_rdata[7:0];
        half_c  = addr_q[1] ? lsu.mem_rdata[31:16] : lsu.mem_rdata[15:0];
        merge_c = lsu.mem_rdata;
        case (addr_q[1:0])
            2'd0: byte_c = lsu.mem_rdata[7:0];
            2'd1: byte_c = lsu.mem_rdata[15:8];
            2'd2: byte_c = lsu.mem_rdata[23:16];
            2'd3: byte_c = lsu.mem_rdata[31:24];
        endcase
        case (funct3_q)
            F3_B:    load_c = {{24{byte_c[7]}}, byte_c};
            F3_BU:   load_c = {24'h0, byte_c};
            F3_H:    load_c = {{16{half_c[15]}}, half_c};
            F3_HU:   load_c = {16'h0, half_c};
            default: load_c = lsu.mem_rdata;
        endcase
        if (funct3_q == F3_B) begin
            case (addr_q[1:0])
                2'd0: merge_c[7:0]   = wdata_q[7:0];
                2'd1: merge_c[15:8]  = wdata_q[7:0];
                2'd2: merge_c[23:16] = wdata_q[7:0];
                2'd3: merge_c[31:24] = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merge_c[31:16] = wdata_q[15:0];
        end else begin
            merge_c[15:0]  = wdata_q[15:0];
        end
    end

    // Next-state and memory/handshake decode
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        req_ready_c = 1'b0;
        rsp_valid_c = 1'b0;
        mem_we_c    = 1'b0;
        mem_addr_c  = 32'h0;
        mem_wdata_c = 32'h0;
        unique case (state_q)
            IDLE: begin
                req_ready_c = 1'b1;
                if (lsu.req_valid) begin
                    we_d     = lsu.req_we;
                    funct3_d = lsu.req_funct3;
                    addr_d   = lsu.req_addr;
                    wdata_d  = lsu.req_wdata;
                    rdata_d  = 32'h0;
                    err_d    = illegal_c;
                    state_d  = illegal_c ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                mem_addr_c = {addr_q[31:2], 2'b00};
                if (we_q && funct3_q == F3_W) begin
                    mem_we_c    = 1'b1;
                    mem_wdata_c = wdata_q;
                    state_d     = RESP;
                end else begin
                    state_d = DATA;
                end
            end
            DATA: begin
                mem_addr_c = {addr_q[31:2], 2'b00};
                if (we_q) begin
                    mem_we_c    = 1'b1;
                    mem_wdata_c = merge_c;
                end else begin
                    rdata_d = load_c;
                end
                state_d = RESP;
            end
            RESP: begin
                rsp_valid_c = 1'b1;
                if (lsu.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latched request registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign lsu.req_ready = req_ready_c;
    assign lsu.rsp_valid = rsp_valid_c;
    assign lsu.rsp_rdata = rdata_q;
    assign lsu.rsp_err   = err_q;
    assign lsu.mem_we    = mem_we_c;
    assign lsu.mem_addr  = mem_addr_c;
    assign lsu.mem_wdata = mem_wdata_c;
endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a behavioural synchronous memory and
// a queue of expected responses.
module tb_lsu_mem_master;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_mem_master_if mif ();
    lsu_mem_master #(.DEPTH_WORDS(256)) dut (.clk(clk), .rst_n(rst_n), .lsu(mif));

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          wes;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    // Behavioural memory: 1-cycle registered read, word write, plus preload port
    logic [31:0] mem [0:255];
    logic        pl_we = 1'b0;
    logic [7:0]  pl_idx = 8'h0;
    logic [31:0] pl_data = 32'h0;
    int          we_cnt = 0;
    logic [31:0] last_we_addr = 32'h0;

    always @(posedge clk) begin
        if (pl_we) mem[pl_idx] <= pl_data;
        else if (mif.mem_we) mem[mif.mem_addr[9:2]] <= mif.mem_wdata;
        mif.mem_rdata <= mem[mif.mem_addr[9:2]];
        if (mif.mem_we) begin
            we_cnt       = we_cnt + 1;
            last_we_addr = mif.mem_addr;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [31:0] byte_addr, input logic [31:0] data);
        @(negedge clk);
        pl_we = 1'b1; pl_idx = byte_addr[9:2]; pl_data = data;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    // One request through to its response handshake; hold>0 stalls rsp_ready
    // while a competing request is presented.
    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_lat, input int exp_wes, input int hold);
        exp_t e;
        int   lat;
        int   we0;
        sb.push_back('{exp_rdata, exp_err, exp_lat, exp_wes});
        we0 = we_cnt;
        @(negedge clk);
        check({tag, "_req_ready"}, 32'(mif.req_ready), 32'd1);
        mif.req_valid = 1'b1; mif.req_we = we; mif.req_funct3 = f3;
        mif.req_addr = addr; mif.req_wdata = wdata;
        @(posedge clk); #1;
        mif.req_valid = 1'b0;
        lat = 1;
        while (!mif.rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb.pop_front();
        check({tag, "_lat"},   32'(lat), 32'(e.lat));
        check({tag, "_rdata"}, mif.rsp_rdata, e.rdata);
        check({tag, "_err"},   32'(mif.rsp_err), 32'(e.err));
        if (hold > 0) begin
            mif.req_valid = 1'b1; mif.req_we = 1'b0; mif.req_funct3 = 3'b010;
            mif.req_addr = 32'h0;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                check({tag, "_hold_valid"}, 32'(mif.rsp_valid), 32'd1);
                check({tag, "_hold_rdata"}, mif.rsp_rdata, e.rdata);
                check({tag, "_hold_ready"}, 32'(mif.req_ready), 32'd0);
            end
            mif.req_valid = 1'b0;
        end
        @(negedge clk);
        mif.rsp_ready = 1'b1;
        @(posedge clk); #1;
        mif.rsp_ready = 1'b0;
        check({tag, "_rsp_drop"}, 32'(mif.rsp_valid), 32'd0);
        check({tag, "_idle"},     32'(mif.req_ready), 32'd1);
        check({tag, "_we_pulses"}, 32'(we_cnt - we0), 32'(e.wes));
    endtask

    initial begin
        int we0;
        mif.req_valid = 1'b0; mif.req_we = 1'b0; mif.req_funct3 = 3'b0;
        mif.req_addr = 32'h0; mif.req_wdata = 32'h0; mif.rsp_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        #1;
        check("rst_req_ready", 32'(mif.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(mif.rsp_valid), 32'd0);
        check("rst_rsp_err",   32'(mif.rsp_err),   32'd0);
        check("rst_rsp_rdata", mif.rsp_rdata,      32'h0);
        check("rst_mem_we",    32'(mif.mem_we),    32'd0);
        check("rst_mem_addr",  mif.mem_addr,       32'h0);
        check("rst_mem_wdata", mif.mem_wdata,      32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Loads with sign/zero extension
        preload(32'h40, 32'h8899AABB);
        do_req("lb",  1'b0, 3'b000, 32'h41, 32'h0, 32'hFFFFFFAA, 1'b0, 3, 0, 0);
        do_req("lbu", 1'b0, 3'b100, 32'h41, 32'h0, 32'h000000AA, 1'b0, 3, 0, 0);
        do_req("lh",  1'b0, 3'b001, 32'h42, 32'h0, 32'hFFFF8899, 1'b0, 3, 0, 0);
        do_req("lhu", 1'b0, 3'b101, 32'h40, 32'h0, 32'h0000AABB, 1'b0, 3, 0, 0);
        do_req("lw",  1'b0, 3'b010, 32'h40, 32'h0, 32'h8899AABB, 1'b0, 3, 0, 0);

        // Sub-word stores via read-modify-write
        preload(32'h40, 32'h11223344);
        do_req("sh", 1'b1, 3'b001, 32'h42, 32'h0000BEEF, 32'h0, 1'b0, 3, 1, 0);
        check("sh_word", mem[16], 32'hBEEF3344);
        do_req("sb", 1'b1, 3'b000, 32'h40, 32'h00000055, 32'h0, 1'b0, 3, 1, 0);
        check("sb_word", mem[16], 32'hBEEF3355);
        do_req("sb3", 1'b1, 3'b000, 32'h43, 32'hFFFFFF01, 32'h0, 1'b0, 3, 1, 0);
        check("sb3_word", mem[16], 32'h01EF3355);

        // Full-word store
        do_req("sw", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1, 0);
        check("sw_addr", last_we_addr, 32'h10);
        check("sw_word", mem[4], 32'hDEADBEEF);

        // Errors: no memory access, 1-cycle response
        do_req("e_lw22", 1'b0, 3'b010, 32'h22,  32'h0, 32'h0, 1'b1, 1, 0, 0);
        do_req("e_sh11", 1'b1, 3'b001, 32'h11,  32'h0, 32'h0, 1'b1, 1, 0, 0);
        do_req("e_lb400", 1'b0, 3'b000, 32'h400, 32'h0, 32'h0, 1'b1, 1, 0, 0);
        do_req("e_f011", 1'b0, 3'b011, 32'h0,   32'h0, 32'h0, 1'b1, 1, 0, 0);
        do_req("e_sbu",  1'b1, 3'b100, 32'h4,   32'h0, 32'h0, 1'b1, 1, 0, 0);
        do_req("e_lhu",  1'b0, 3'b101, 32'h43,  32'h0, 32'h0, 1'b1, 1, 0, 0);
        do_req("ok_top", 1'b0, 3'b010, 32'h3FC, 32'h0, 32'h0, 1'b0, 3, 0, 0);
        check("err_words_intact", mem[4], 32'hDEADBEEF);

        // Back-pressure in RESP with a competing request
        do_req("hold", 1'b0, 3'b010, 32'h40, 32'h0, 32'h01EF3355, 1'b0, 3, 0, 5);

        // Reset during the DATA cycle of a byte store
        preload(32'h80, 32'hCAFEF00D);
        we0 = we_cnt;
        @(negedge clk);
        mif.req_valid = 1'b1; mif.req_we = 1'b1; mif.req_funct3 = 3'b000;
        mif.req_addr = 32'h81; mif.req_wdata = 32'h77;
        @(posedge clk); #1;
        mif.req_valid = 1'b0;
        @(posedge clk); #1;
        check("rmw_data_we", 32'(mif.mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rmw_rst_we", 32'(mif.mem_we), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rmw_rst_word",  mem[32], 32'hCAFEF00D);
        check("rmw_rst_ready", 32'(mif.req_ready), 32'd1);
        check("rmw_rst_valid", 32'(mif.rsp_valid), 32'd0);
        check("rmw_rst_pulses", 32'(we_cnt - we0), 32'd0);

        // Unit still works after the mid-operation reset
        do_req("post_rst", 1'b0, 3'b000, 32'h81, 32'h0, 32'hFFFFFFF0, 1'b0, 3, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
